// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned RZERO    = 0;

  typedef enum logic {
    WP_ALU = 1'b0,
    WP_MEM = 1'b1
  } wr_path_e;

  // Largest value a pending counter of width w can hold.
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: pending-write counter plus load-ness bit for a single register.
module sb_entry
  import regfile_pkg::*;
#(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned HW    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          issue_hit_i,
  input  logic          issue_load_i,
  input  logic [HW-1:0] wr_hits_i,
  input  logic          flush_i,
  output logic          cnt_nz_o,
  output logic          at_max_o,
  output logic          is_load_o
);

  localparam int unsigned CntMax = cnt_max(CNT_W);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic             r_load;
  logic             w_load_d;
  int               w_sum;

  always_comb begin
    w_sum = int'(r_cnt) + int'(issue_hit_i) - int'(wr_hits_i);
    if (flush_i || w_sum <= 0) begin
      w_cnt_d = '0;
    end else if (w_sum >= int'(CntMax)) begin
      w_cnt_d = CNT_W'(CntMax);
    end else begin
      w_cnt_d = CNT_W'(w_sum);
    end

    if (w_cnt_d == '0) begin
      w_load_d = 1'b0;
    end else if (issue_hit_i && issue_load_i) begin
      w_load_d = 1'b1;
    end else begin
      w_load_d = r_load;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_load <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_d;
      r_load <= w_load_d;
    end
  end

  assign cnt_nz_o  = (r_cnt != '0);
  assign at_max_o  = (r_cnt == CNT_W'(CntMax));
  assign is_load_o = r_load;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass and pending-write scoreboard.
// Bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREG  = NREG_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NRD-1:0]                rd_en_i,
  input  logic [NRD*$clog2(NREG)-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0]           rd_data_o,
  input  logic                          issue_en_i,
  input  logic [$clog2(NREG)-1:0]       issue_rd_i,
  input  logic                          issue_load_i,
  input  logic [NWR-1:0]                wr_en_i,
  input  logic [NWR*$clog2(NREG)-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0]           wr_data_i,
  input  logic                          flush_i,
  output logic                          stall_o,
  output logic [NREG-1:0]               busy_o
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned HW = $clog2(NWR + 1);
`ifdef REGFILE_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  logic [XLEN-1:0] r_regs [NREG];
  logic [HW-1:0]   w_wr_hits [NREG];
  logic [NREG-1:0] w_cnt_nz;
  logic [NREG-1:0] w_at_max;
  logic [NREG-1:0] w_is_load;
  logic            w_issue_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
    end else begin
      // Later ports overwrite earlier ones, so the highest index wins.
      for (int j = 0; j < int'(NWR); j++) begin
        if (wr_en_i[j] && wr_addr_i[j*AW +: AW] != AW'(RZERO)) begin
          r_regs[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NREG); i++) w_wr_hits[i] = '0;
    for (int j = 0; j < int'(NWR); j++) begin
      if (wr_en_i[j] && wr_addr_i[j*AW +: AW] != AW'(RZERO)) begin
        w_wr_hits[wr_addr_i[j*AW +: AW]] = w_wr_hits[wr_addr_i[j*AW +: AW]] + HW'(1);
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < int'(NRD); k++) begin
      if (rd_addr_i[k*AW +: AW] != AW'(RZERO)) begin
        rd_data_o[k*XLEN +: XLEN] = r_regs[rd_addr_i[k*AW +: AW]];
        if (BypassEn) begin
          for (int j = 0; j < int'(NWR); j++) begin
            if (wr_en_i[j] && wr_addr_i[j*AW +: AW] == rd_addr_i[k*AW +: AW]) begin
              rd_data_o[k*XLEN +: XLEN] = wr_data_i[j*XLEN +: XLEN];
            end
          end
        end
      end
    end
  end

  always_comb begin
    stall_o = 1'b0;
    for (int k = 0; k < int'(NRD); k++) begin
      if (rd_en_i[k] && rd_addr_i[k*AW +: AW] != AW'(RZERO) &&
          w_is_load[rd_addr_i[k*AW +: AW]] && w_cnt_nz[rd_addr_i[k*AW +: AW]] &&
          !(BypassEn && w_wr_hits[rd_addr_i[k*AW +: AW]] != '0)) begin
        stall_o = 1'b1;
      end
    end
    if (issue_en_i && issue_rd_i != AW'(RZERO) && w_at_max[issue_rd_i]) begin
      stall_o = 1'b1;
    end
  end

  assign w_issue_ok = issue_en_i && !stall_o && !flush_i;

  assign w_cnt_nz[0]  = 1'b0;
  assign w_at_max[0]  = 1'b0;
  assign w_is_load[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_entry
    sb_entry #(
      .CNT_W (CNT_W),
      .HW    (HW)
    ) u_entry (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .issue_hit_i  (w_issue_ok && issue_rd_i == AW'(i)),
      .issue_load_i (issue_load_i),
      .wr_hits_i    (w_wr_hits[i]),
      .flush_i      (flush_i),
      .cnt_nz_o     (w_cnt_nz[i]),
      .at_max_o     (w_at_max[i]),
      .is_load_o    (w_is_load[i])
    );
  end

  assign busy_o = w_cnt_nz;

endmodule
